comb_resp_misr: RTL and testbench

- Response-side companion to the exhaustive stimulus sweep of the combinational block (inputs A..F, outputs Y1..Y5).
- Consumes one RESP_W-bit response vector per accepted beat over a valid/ready handshake.
- Compacts the vectors into a Galois multiple-input signature register (MISR), counts N_VEC beats, then compares the signature against an expected value and reports pass/fail.
- Used as the hardware checker for self-checking sweeps of the combinational functions.

---
 rtl/comb_resp_misr_pkg.sv | 35 +++
 rtl/comb_resp_misr_misr_reg.sv | 40 ++++
 rtl/comb_resp_misr.sv | 104 ++++++++++
 tb/tb_comb_resp_misr.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/comb_resp_misr_pkg.sv
// ============================================================================
// Module      : comb_resp_misr_pkg
// Description : Shared types, defaults and MISR update function for the
//               combinational-block response checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package comb_resp_misr_pkg;

  localparam int              RESP_W_DEF = 5;
  localparam logic [4:0]      POLY_DEF   = 5'h05;
  localparam logic [4:0]      SEED_DEF   = 5'h00;
  localparam int              N_VEC_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Galois MISR step at the default width and polynomial.
  function automatic logic [RESP_W_DEF-1:0] misr_next(
    input logic [RESP_W_DEF-1:0] sig,
    input logic [RESP_W_DEF-1:0] resp
  );
    logic [RESP_W_DEF-1:0] fb;
    fb = sig[RESP_W_DEF-1] ? POLY_DEF : '0;
    return {sig[RESP_W_DEF-2:0], 1'b0} ^ fb ^ resp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comb_resp_misr_misr_reg.sv
// ============================================================================
// Module      : misr_reg
// Description : RESP_W-bit Galois multiple-input signature register with
//               synchronous seed load and compaction enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module misr_reg
  import comb_resp_misr_pkg::*;
#(
  parameter int                RESP_W = RESP_W_DEF,
  parameter logic [RESP_W-1:0] POLY   = POLY_DEF,
  parameter logic [RESP_W-1:0] SEED   = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] sig
);

  logic [RESP_W-1:0] sig_next;

  always_comb begin
    sig_next = {sig[RESP_W-2:0], 1'b0} ^ resp;
    if (sig[RESP_W-1]) sig_next = sig_next ^ POLY;
  end

  // Load outranks enable so an abort or restart always returns to the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sig <= SEED;
    else if (load) sig <= SEED;
    else if (en)   sig <= sig_next;
  end

endmodule

`default_nettype wire

// File: rtl/comb_resp_misr.sv
// ============================================================================
// Module      : comb_resp_misr
// Description : Response checker: compacts N_VEC handshaked response beats
//               into a MISR signature and compares it with an expected value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comb_resp_misr
  import comb_resp_misr_pkg::*;
#(
  parameter int                RESP_W = RESP_W_DEF,
  parameter int                N_VEC  = N_VEC_DEF,
  parameter logic [RESP_W-1:0] POLY   = POLY_DEF,
  parameter logic [RESP_W-1:0] SEED   = SEED_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [RESP_W-1:0]          exp_sig,
  input  logic                       in_valid,
  input  logic [RESP_W-1:0]          in_resp,
  output logic                       in_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [RESP_W-1:0]          signature,
  output logic [$clog2(N_VEC+1)-1:0] vec_count
);

  localparam int CNT_W = $clog2(N_VEC+1);

  state_t             state;
  logic [RESP_W-1:0]  exp_lat;
  logic [CNT_W-1:0]   cnt;
  logic               start_ok;
  logic               abort_ok;
  logic               accept;
  logic               last_beat;

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign abort_ok  = abort && (state == RUN);
  // Abort takes priority: a beat presented alongside it is dropped.
  assign accept    = in_valid && (state == RUN) && !abort;
  assign last_beat = (cnt == CNT_W'(N_VEC - 1));

  misr_reg #(
    .RESP_W (RESP_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok || abort_ok),
    .en   (accept),
    .resp (in_resp),
    .sig  (signature)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      exp_lat <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            cnt     <= '0;
            exp_lat <= exp_sig;
            done    <= 1'b0;
            pass    <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (abort_ok) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) state <= CHECK;
          end
        end
        CHECK: begin
          pass  <= (signature == exp_lat);
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN) || (state == CHECK);
  assign vec_count = cnt;

endmodule

`default_nettype wire

// File: tb/tb_comb_resp_misr.sv
// ============================================================================
// Module      : tb_comb_resp_misr
// Description : Scoreboard bench for comb_resp_misr with directed streams.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comb_resp_misr;
  import comb_resp_misr_pkg::*;

  typedef struct packed {
    logic [4:0] sig;
    logic       pass;
    logic [6:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [4:0] exp_sig;
  logic       in_valid;
  logic [4:0] in_resp;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] signature;
  logic [6:0] vec_count;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  comb_resp_misr dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .exp_sig   (exp_sig),
    .in_valid  (in_valid),
    .in_resp   (in_resp),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .vec_count (vec_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: each completed run (rising done) is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && done && !prev_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_signature", 32'(signature), 32'(e.sig));
        chk("sb_pass",      32'(pass),      32'(e.pass));
        chk("sb_vec_count", 32'(vec_count), 32'(e.cnt));
      end
    end
    prev_done = done;
  end

  task automatic start_run(input logic [4:0] e);
    exp_sig = e;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Drive beats 0..n-1; beat inj_idx carries inj_val, the rest are zero.
  task automatic send_beats(input int n, input int inj_idx, input logic [4:0] inj_val,
                            input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      if (!in_ready) chk("in_ready_in_run", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_resp  = (i == inj_idx) ? inj_val : 5'h00;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_resp  = 5'h00;
    end
  endtask

  // Full run with latency check; expectation is pushed when stimulus is issued.
  task automatic full_run(input logic [4:0] e, input int inj_idx, input logic [4:0] inj_val,
                          input bit gaps, input logic [4:0] want_sig, input logic want_pass);
    int wait_cyc;
    sb_q.push_back('{sig: want_sig, pass: want_pass, cnt: 7'd64});
    start_run(e);
    send_beats(64, inj_idx, inj_val, gaps);
    chk("done_low_1edge", 32'(done), 32'd0);
    wait_cyc = 0;
    while (!done && wait_cyc < 8) begin @(posedge clk); #1; wait_cyc++; end
    chk("done_latency_edges", 32'(wait_cyc), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; exp_sig = '0;
    in_valid = 1'b0; in_resp = '0;
    #12;
    chk("rst_signature", 32'(signature), 32'h00);
    chk("rst_vec_count", 32'(vec_count), 32'd0);
    chk("rst_ready_busy_done_pass", {28'd0, in_ready, busy, done, pass}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // All zeros
    full_run(5'h00, -1, 5'h00, 1'b0, 5'h00, 1'b1);
    // Single injected error at beat 0: x^63 mod poly = x
    full_run(5'h02, 0, 5'h01, 1'b0, 5'h02, 1'b1);
    full_run(5'h00, 0, 5'h01, 1'b0, 5'h02, 1'b0);
    // Last-beat injection
    full_run(5'h1F, 63, 5'h1F, 1'b0, 5'h1F, 1'b1);
    full_run(5'h1E, 63, 5'h1F, 1'b0, 5'h1F, 1'b0);

    // in_valid in DONE is ignored
    in_valid = 1'b1; in_resp = 5'h1F;
    repeat (3) begin @(posedge clk); #1; end
    chk("done_ignores_valid_ready", 32'(in_ready), 32'd0);
    chk("done_ignores_valid_sig", 32'(signature), 32'h1F);
    chk("done_ignores_valid_cnt", 32'(vec_count), 32'd64);
    in_valid = 1'b0;
    // Gapped stream must give the same signature
    full_run(5'h02, 0, 5'h01, 1'b1, 5'h02, 1'b1);

    // Abort and ignored start
    start_run(5'h00);
    send_beats(10, 0, 5'h01, 1'b0);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("ignored_start_cnt", 32'(vec_count), 32'd10);
    chk("ignored_start_busy", 32'(busy), 32'd1);
    abort = 1'b1; in_valid = 1'b1; in_resp = 5'h1F;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0; in_resp = 5'h00;
    chk("abort_cnt", 32'(vec_count), 32'd0);
    chk("abort_sig", 32'(signature), 32'h00);
    chk("abort_ready_busy_done", {29'd0, in_ready, busy, done}, 32'd0);
    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_resp = 5'h1F;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_ignores_valid_cnt", 32'(vec_count), 32'd0);
    chk("idle_ignores_valid_sig", 32'(signature), 32'h00);
    in_valid = 1'b0;
    full_run(5'h1F, 63, 5'h1F, 1'b0, 5'h1F, 1'b1);

    // Async reset mid-run
    start_run(5'h00);
    send_beats(20, 0, 5'h01, 1'b0);
    chk("pre_reset_cnt", 32'(vec_count), 32'd20);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sig", 32'(signature), 32'h00);
    chk("async_rst_cnt", 32'(vec_count), 32'd0);
    chk("async_rst_flags", {28'd0, in_ready, busy, done, pass}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    full_run(5'h00, -1, 5'h00, 1'b0, 5'h00, 1'b1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
